mac_arbiter: RTL
================

# mac_arbiter

Round-robin arbiter and sequencer that shares one `mac_topmodule` instance among `NREQ` requesters. It captures the winning requester's 4-bit operands and drives them onto the MAC. It issues the `go` pulse, waits for `done` (guarded by a watchdog) and returns the 12-bit result to the winner with a one-cycle acknowledge. It sits between the client blocks and the MAC's `A`/`B`/`go`/`out`/`done` pins; the MAC shares `clk` and `rst`.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 255: maximum number of WAIT cycles without `mac_done` before the transaction is aborted. Range 1..65535.
- `IDW`, default `$clog2(NREQ)`: grant index width; derived, not overridden.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `req_a`  in  4*NREQ  operand A, requester i on bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B, same packing as `req_a`.
- `ack`  out  NREQ  one-cycle completion pulse to the served requester.
- `rsp_out`  out  12  result; valid only while any `ack` bit is high.
- `rsp_err`  out  1  timeout flag; valid with `ack`.
- `busy`  out  1  high in every state except IDLE.
- `gnt_id`  out  IDW  index of the current or last granted requester.
- `mac_a`, `mac_b`  out  4  operands to the MAC; held constant from ISSUE through WAIT.
- `mac_go`  out  1  one-cycle start pulse to the MAC.
- `mac_done`  in  1  MAC completion; pulse or level is accepted.
- `mac_out`  in  12  MAC result, sampled in the cycle `mac_done` is seen.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If `req` is nonzero and `mac_done` is 0, arbitrate.
  - The winner is the first set bit scanning upward from `ptr`, with wrap-around.
  - Register `gnt_id`, and capture that requester's `req_a`/`req_b` into operand registers.
  - Go to ISSUE.
  - While `mac_done` is high, stay in IDLE. This covers a MAC still holding a level `done`.
- **ISSUE**
  - `mac_go` = 1 for exactly this cycle.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**
  - Watchdog increments every cycle.
  - If `mac_done` = 1: latch `mac_out` into the result register, set err = 0 and go to RESP.
  - Else if watchdog = TIMEOUT: set the result register to 0, set err = 1 and go to RESP.
  - `mac_done` has priority if both conditions hit in the same cycle.
- **RESP**
  - `ack[gnt_id]` = 1 for one cycle, with `rsp_out`/`rsp_err` driven from the registers.
  - Set `ptr` = `gnt_id` + 1, modulo NREQ.
  - Go to IDLE.
- **Operand capture**
  - Operands are captured at grant.
  - Requester operand changes after the grant cycle have no effect.
  - The requester must keep `req` high only until grant. Dropping `req` after grant does not cancel the transaction; `ack` still pulses.
- **Requests and fairness**
  - A request dropped before grant is never served.
  - Requesters that keep `req` high are served in strict rotation.
  - With all NREQ requesting, each is served once per NREQ transactions.
- `rsp_out` and `rsp_err` are 0 whenever `ack` is 0.
- `mac_a`/`mac_b` always reflect the operand registers.

## Timing
- **Reset** (`rst` sampled high, any state):
  - State goes to IDLE; `ptr`, `gnt_id` and the watchdog go to 0.
  - All outputs go to 0: `ack`, `rsp_out`, `rsp_err`, `busy`, `mac_go`, `mac_a`, `mac_b`.
  - An in-flight transaction is dropped with no `ack`; the MAC is reset by the same `rst`.
- **Cycle numbering:** `req` is seen in IDLE at cycle 0.
  - Cycle 1: ISSUE, `mac_go` = 1, `busy` = 1.
  - Cycle 2 onward: WAIT.
  - If `mac_done` is first high at cycle d, then RESP and `ack` are at cycle d+1. IDLE is at cycle d+2.
  - Minimum request-to-`ack` latency is 3 cycles, when `mac_done` arrives at cycle 2.
- **Timeout:** with no `mac_done`, `ack` with `rsp_err` = 1 occurs at cycle TIMEOUT+3.
- **Back-to-back:** a new grant can occur in the IDLE cycle right after RESP, giving one transaction per d+2 cycles.
- `mac_done` high in IDLE, ISSUE or RESP is ignored, apart from the IDLE wait rule.

## Test plan
- **Reset defaults:** assert `rst` for 2 cycles mid-WAIT -> all outputs 0, no `ack`. Then `req` = 0001 with A = 3, B = 5 -> `gnt_id` = 0 and `mac_go` one cycle later.
- **Single transaction with a behavioral MAC model:** requester 2 with A = 7, B = 9. MAC model asserts `mac_done` 4 cycles after `mac_go` with `mac_out` = 63 -> `ack` = 0100, `rsp_out` = 63, `rsp_err` = 0, exactly once.
- **Round-robin:** `req` = 1111 held continuously -> grant order 0, 1, 2, 3, 0. Then `req` = 1010 after serving 1 -> next grant is 3, then 1.
- **Operand stability:** change `req_a[3:0]` from 4 to 15 during WAIT -> `mac_a` stays 4 through WAIT. Drop `req[0]` after grant -> `ack[0]` still pulses.
- **Timeout:** MAC model never asserts `mac_done`, TIMEOUT = 10 -> `ack` with `rsp_err` = 1 and `rsp_out` = 0 at cycle 13. `busy` is then 0 and the next request is served normally.
- **Level `done` hold-off:** MAC model holds `mac_done` high for 5 cycles after completion while `req` = 0010 -> grant is deferred until `mac_done` = 0, and `mac_go` follows one cycle later.

Source files
------------

// File: rtl/mac_arbiter.sv
// -----------------------------------------------------------------------------
// mac_arbiter
//
// Shares one MAC among NREQ requesters. A round-robin arbiter picks a winner,
// its 4-bit operands are captured and held on mac_a_o/mac_b_o, a one-cycle
// mac_go_o pulse starts the MAC, and the 12-bit result (or a watchdog timeout)
// is returned to the winner with a one-cycle ack.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   req_i        per-requester request level
//   req_a_i      operand A, requester i on bits [4i+3:4i]
//   req_b_i      operand B, same packing as req_a_i
//   ack_o        one-cycle completion pulse to the served requester
//   rsp_out_o    result, nonzero only while ack_o is nonzero
//   rsp_err_o    timeout flag, valid with ack_o
//   busy_o       high in every state except IDLE
//   gnt_id_o     index of the current or last granted requester
//   mac_a_o      operand A to the MAC, stable from ISSUE through WAIT
//   mac_b_o      operand B to the MAC, stable from ISSUE through WAIT
//   mac_go_o     one-cycle MAC start pulse
//   mac_done_i   MAC completion (pulse or level)
//   mac_out_i    MAC result, sampled in the cycle mac_done_i is seen
//
// All outputs are registered: each output register is loaded from a value
// derived from the next state, so it lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module mac_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [4*NREQ-1:0]    req_a_i,
    input  logic [4*NREQ-1:0]    req_b_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [11:0]          rsp_out_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic [IDW-1:0]       gnt_id_o,
    output logic [3:0]           mac_a_o,
    output logic [3:0]           mac_b_o,
    output logic                 mac_go_o,
    input  logic                 mac_done_i,
    input  logic [11:0]          mac_out_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // FSM and datapath state
    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q,   ptr_d;
    logic [IDW-1:0]    gnt_q,   gnt_d;
    logic [15:0]       wdog_q,  wdog_d;
    logic [3:0]        opa_q,   opa_d;
    logic [3:0]        opb_q,   opb_d;

    // Output registers
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic [11:0]       rsp_q,   rsp_d;
    logic              err_q,   err_d;
    logic              busy_q,  busy_d;
    logic              go_q,    go_d;

    // Arbiter results
    logic              req_any_s;
    logic              win_found_s;
    logic [IDW-1:0]    win_id_s;
    logic [IDW-1:0]    scan_idx_s;
    logic              scan_hit_s;
    logic [3:0]        win_a_s;
    logic [3:0]        win_b_s;
    logic [NREQ-1:0]   gnt_onehot_s;

    assign req_any_s    = |req_i;
    assign gnt_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;

    // Round-robin winner: first set request scanning upward from ptr_q, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        scan_idx_s  = '0;
        scan_hit_s  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx_s  = IDW'((int'(ptr_q) + i) % NREQ);
            scan_hit_s  = req_i[scan_idx_s] & ~win_found_s;
            win_id_s    = scan_hit_s ? scan_idx_s : win_id_s;
            win_found_s = win_found_s | scan_hit_s;
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_a_s = 4'd0;
        win_b_s = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            win_a_s = (win_id_s == IDW'(i)) ? req_a_i[4*i +: 4] : win_a_s;
            win_b_s = (win_id_s == IDW'(i)) ? req_b_i[4*i +: 4] : win_b_s;
        end
    end

    // Next-state logic and next values of all registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wdog_d  = wdog_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ack_d   = '0;
        rsp_d   = 12'd0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A MAC still holding a level done must release it before a new
                // grant, otherwise the stale done would complete the next job.
                if (req_any_s && win_found_s && !mac_done_i) begin
                    state_d = S_ISSUE;
                    gnt_d   = win_id_s;
                    opa_d   = win_a_s;
                    opb_d   = win_b_s;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                wdog_d  = 16'd0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                wdog_d = wdog_q + 16'd1;
                // done wins over the watchdog when both hit in the same cycle
                if (mac_done_i) begin
                    state_d = S_RESP;
                    ack_d   = gnt_onehot_s;
                    rsp_d   = mac_out_i;
                    err_d   = 1'b0;
                end else if (wdog_q == 16'(TIMEOUT)) begin
                    state_d = S_RESP;
                    ack_d   = gnt_onehot_s;
                    rsp_d   = 12'd0;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_RESP: begin
                ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        go_d   = (state_d == S_ISSUE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wdog_q  <= 16'd0;
            opa_q   <= 4'd0;
            opb_q   <= 4'd0;
            ack_q   <= '0;
            rsp_q   <= 12'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wdog_q  <= wdog_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ack_q   <= ack_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
        end
    end

    assign ack_o     = ack_q;
    assign rsp_out_o = rsp_q;
    assign rsp_err_o = err_q;
    assign busy_o    = busy_q;
    assign gnt_id_o  = gnt_q;
    assign mac_a_o   = opa_q;
    assign mac_b_o   = opb_q;
    assign mac_go_o  = go_q;

endmodule
